// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int UART_ARB_N_REQ  = 4;
  localparam int UART_ARB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner selection: search starts at i_ptr, ascends and wraps at N_REQ-1.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = UART_ARB_N_REQ
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_winner,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_valid
);

  localparam int PTR_W = $clog2(N_REQ);

  int w_j;

  always_comb begin
    o_winner = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_j      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!o_valid && i_req[w_j]) begin
        o_valid       = 1'b1;
        o_idx         = PTR_W'(w_j);
        o_winner[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional SEND watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = UART_ARB_N_REQ,
  parameter int DATA_W         = UART_ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic                    tx_rdy,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_win_idx;
  logic [N_REQ-1:0]  r_grant;
  logic [DATA_W-1:0] r_tx_data;

  logic [N_REQ-1:0]  w_pick_winner;
  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic              w_timeout;
  logic [PTR_W-1:0]  w_ptr_next;

  uart_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_winner (w_pick_winner),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_ptr_next = (r_win_idx == PTR_W'(N_REQ - 1)) ? '0 : r_win_idx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        r_err;

  assign w_timeout = (r_state == ST_SEND) && !tx_rdy && (r_wd == 32'(TIMEOUT_CYCLES - 1));

  // Counter is zero on the first SEND cycle, so the abort lands after TIMEOUT_CYCLES SEND cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_LOAD)      r_wd <= '0;
      else if (r_state == ST_SEND) r_wd <= r_wd + 32'd1;
      if (w_timeout)               r_err <= 1'b1;
      else if (r_state == ST_ACK)  r_err <= 1'b0;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Handshake: req_i is a level held until ack_o; tx_start is held through SEND and the frame
  // completes on the first edge that samples tx_rdy=1 while in SEND (tx_rdy is ignored elsewhere).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_win_idx <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state   <= ST_LOAD;
            r_grant   <= w_pick_winner;
            r_win_idx <= w_pick_idx;
            r_tx_data <= data_i[int'(w_pick_idx)*DATA_W +: DATA_W];
          end
        end
        ST_LOAD: r_state <= ST_SEND;
        ST_SEND: begin
          if (tx_rdy || w_timeout) r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_ptr   <= w_ptr_next;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start  = (r_state == ST_SEND);
  assign tx_data_o = r_tx_data;
  assign grant_o   = r_grant;
  assign ack_o     = (r_state == ST_ACK) ? r_grant : '0;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with an ack scoreboard; honours UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int EW = 1 + N + DW;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic            tx_rdy;
  logic            tx_start;
  logic [DW-1:0]   tx_data_o;
  logic [N-1:0]    grant_o;
  logic [N-1:0]    ack_o;
  logic            busy_o;
  logic            err_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  int            ack_cyc[$];

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .data_i    (data_i),
    .tx_rdy    (tx_rdy),
    .tx_start  (tx_start),
    .tx_data_o (tx_data_o),
    .grant_o   (grant_o),
    .ack_o     (ack_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  // clock / reset-independent cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [EW-1:0] exp_entry(input int idx, input logic err);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return {err, oh, data_i[idx*DW +: DW]};
  endfunction

  // Runs until n ack pulses are seen; optionally drops the served request as a requester would.
  task automatic run_acks(input int n, input bit drop_on_ack);
    int seen;
    int budget;
    seen   = 0;
    budget = 0;
    while (seen < n && budget < 400) begin
      tick();
      budget++;
      if (ack_o != '0) begin
        seen++;
        if (drop_on_ack) req_i = req_i & ~ack_o;
      end
    end
    check("acks_within_budget", seen, n);
  endtask

  // scoreboard / monitor
  always @(posedge clk_i) begin
    logic [EW-1:0] e;
    #1;
    if (rst_i) begin
      check("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
      check("ack_onehot0", 32'($onehot0(ack_o)), 32'd1);
      if (ack_o != '0) begin
        ack_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_entry", 32'({err_o, ack_o, tx_data_o}), 32'(e));
        end
      end else begin
        check("err_without_ack", 32'(err_o), 32'd0);
      end
    end
  end

  initial begin
    int n;
    int base;
    req_i  = '0;
    data_i = 32'h4DC3A51E;
    tx_rdy = 1'b0;
    rst_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_grant", grant_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_tx_data", tx_data_o, 0);

    rst_i  = 1'b1;
    tx_rdy = 1'b1;
    tick();
    tick();
    check("idle_rdy_busy", busy_o, 0);
    check("idle_rdy_tx_start", tx_start, 0);
    tx_rdy = 1'b0;

    // single request, ready on third SEND cycle, data changed mid-SEND
    exp_q.push_back(exp_entry(1, 1'b0));
    req_i = 4'b0010;
    tick();
    check("load_grant", grant_o, 4'b0010);
    check("load_tx_data", tx_data_o, 8'hA5);
    check("load_tx_start", tx_start, 0);
    check("load_busy", busy_o, 1);
    tick();
    data_i[15:8] = 8'hFF;
    n = 0;
    while (tx_start === 1'b1 && n < 20) begin
      n++;
      if (n == 3) tx_rdy = 1'b1;
      tick();
    end
    check("single_tx_start_cycles", n, 3);
    check("single_ack", ack_o, 4'b0010);
    check("single_ack_grant", grant_o, 4'b0010);
    check("send_data_stable", tx_data_o, 8'hA5);
    tx_rdy = 1'b0;
    req_i  = '0;
    data_i = 32'h4DC3A51E;
    tick();
    check("post_ack_grant", grant_o, 0);
    check("post_ack_ack", ack_o, 0);
    check("post_ack_data_hold", tx_data_o, 8'hA5);
    check("post_ack_busy", busy_o, 0);

    // pointer is now 2: 4'b1011 must pick index 3; then reset mid-SEND
    req_i = 4'b1011;
    tick();
    check("rr_from_ptr2", grant_o, 4'b1000);
    tick();
    check("send_before_reset", tx_start, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check("midsend_rst_tx_start", tx_start, 0);
    check("midsend_rst_grant", grant_o, 0);
    check("midsend_rst_busy", busy_o, 0);
    check("midsend_rst_tx_data", tx_data_o, 0);
    tick();
    rst_i  = 1'b1;
    req_i  = 4'b1111;
    tx_rdy = 1'b1;

    // fairness from ptr=0 with all requesters held
    base = ack_cyc.size();
    exp_q.push_back(exp_entry(0, 1'b0));
    exp_q.push_back(exp_entry(1, 1'b0));
    exp_q.push_back(exp_entry(2, 1'b0));
    exp_q.push_back(exp_entry(3, 1'b0));
    exp_q.push_back(exp_entry(0, 1'b0));
    run_acks(5, 1'b0);
    req_i = '0;
    tick();
    check("fair_ack_count", ack_cyc.size() - base, 5);
    for (int k = 1; k < 5; k++) begin
      if (base + k < ack_cyc.size())
        check("fair_ack_spacing", ack_cyc[base+k] - ack_cyc[base+k-1], 4);
    end

    // serve 3 so ptr wraps to 0, then 4'b1001 must serve 0 before 3
    exp_q.push_back(exp_entry(3, 1'b0));
    req_i = 4'b1000;
    run_acks(1, 1'b1);
    exp_q.push_back(exp_entry(0, 1'b0));
    exp_q.push_back(exp_entry(3, 1'b0));
    req_i = 4'b1001;
    run_acks(2, 1'b1);
    tick();

    // requester drops before its ack is still served
    exp_q.push_back(exp_entry(2, 1'b0));
    req_i = 4'b0100;
    tick();
    req_i = '0;
    run_acks(1, 1'b1);
    tick();

    // transmitter never ready
    tx_rdy = 1'b0;
    req_i  = 4'b0001;
`ifdef UART_ARB_TIMEOUT_EN
    exp_q.push_back(exp_entry(0, 1'b1));
    tick();
    tick();
    n = 0;
    while (tx_start === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("timeout_send_cycles", n, TO);
    check("timeout_err", err_o, 1);
    check("timeout_ack", ack_o, 4'b0001);
    req_i = '0;
`else
    exp_q.push_back(exp_entry(0, 1'b0));
    tick();
    tick();
    repeat (40) tick();
    check("no_timeout_tx_start", tx_start, 1);
    check("no_timeout_busy", busy_o, 1);
    check("no_timeout_err", err_o, 0);
    check("no_timeout_grant", grant_o, 4'b0001);
    tx_rdy = 1'b1;
    tick();
    check("late_rdy_ack", ack_o, 4'b0001);
    req_i  = '0;
    tx_rdy = 1'b0;
`endif
    tick();
    tick();
    check("final_busy", busy_o, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
